// File: rtl/otter_fetch_unit_if.sv
// otter_fetch_unit_if
//   Bundle of every signal between the OTTER fetch unit and its neighbours:
//   the instruction-memory request/grant/response port, the IR hand-off
//   register towards decode/execute, and the next-PC inputs from the decoder.
//
//   Handshakes:
//     imem: imem_req is held with a stable imem_addr until a cycle with
//           imem_gnt=1 accepts it. Read data comes back later as a one-cycle
//           imem_rvalid pulse. imem_err is meaningful only when imem_rvalid=1.
//     ir:   ir_valid=1 means ir/ir_pc/ir_fault hold a fetched instruction and
//           stay stable until a cycle with ir_ready=1. That cycle is the
//           hand-off. pc_source and the target addresses must be valid in
//           that same cycle.
//
//   Modports:
//     master - the fetch unit
//     slave  - memory, decoder and consumer side (the testbench)
interface otter_fetch_unit_if;
  // next-PC selection from the decoder
  logic [3:0]  pc_source;
  logic [31:0] jalr_addr;
  logic [31:0] branch_addr;
  logic [31:0] jal_addr;
  logic [31:0] mtvec;
  logic [31:0] mepc;

  // instruction memory port
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;

  // instruction register towards decode/execute
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_fault;

  modport master (
    input  pc_source, jalr_addr, branch_addr, jal_addr, mtvec, mepc,
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata, imem_err,
    output ir_valid, ir, ir_pc, ir_fault,
    input  ir_ready
  );

  modport slave (
    output pc_source, jalr_addr, branch_addr, jal_addr, mtvec, mepc,
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata, imem_err,
    input  ir_valid, ir, ir_pc, ir_fault,
    output ir_ready
  );
endinterface

// File: rtl/otter_fetch_unit.sv
// otter_fetch_unit
//   Instruction fetch stage of the multicycle OTTER core. It owns the program
//   counter and issues one instruction-memory read at a time. The returned
//   word is held in the IR until decode/execute accepts it. On that hand-off
//   the next PC is chosen from pc_source and the decoder's target addresses.
//
//   Ports:
//     clk       rising-edge clock
//     rst_n     asynchronous active-low reset
//     bus       otter_fetch_unit_if.master (imem port, IR port, next-PC inputs)
//     dbg_state current FSM state (0 BOOT, 1 REQ, 2 WAIT, 3 HOLD)
//
//   Parameters:
//     RESET_VEC first fetch address; also the reset value of ir_pc
//     NOP_INSTR IR contents while no instruction is held
module otter_fetch_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst_n,
  otter_fetch_unit_if.master   bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  // pc_source encodings; 6-15 fall through to sequential
  localparam logic [3:0] SRC_JALR   = 4'd1;
  localparam logic [3:0] SRC_BRANCH = 4'd2;
  localparam logic [3:0] SRC_JAL    = 4'd3;
  localparam logic [3:0] SRC_MTVEC  = 4'd4;
  localparam logic [3:0] SRC_MEPC   = 4'd5;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] ir_pc_q;
  logic        ir_fault_q;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic [31:0] next_pc;

  // Sequential successor is based on the address the held instruction came
  // from. The 32-bit add wraps naturally at the top of the address space.
  assign pc_plus4 = ir_pc_q + 32'd4;

  always_comb begin
    target = pc_plus4;
    case (bus.pc_source)
      SRC_JALR:   target = bus.jalr_addr;
      SRC_BRANCH: target = bus.branch_addr;
      SRC_JAL:    target = bus.jal_addr;
      SRC_MTVEC:  target = bus.mtvec;
      SRC_MEPC:   target = bus.mepc;
      default:    target = pc_plus4;
    endcase
  end

  // Fetches are always word aligned. A misaligned JALR target is silently
  // rounded down here instead of being trapped.
  assign next_pc = {target[31:2], 2'b00};

  // A reset in the middle of a transaction drops the outstanding response.
  // A late rvalid then arrives in BOOT or REQ, where it is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_BOOT;
      pc_q       <= RESET_VEC;
      ir_q       <= NOP_INSTR;
      ir_pc_q    <= RESET_VEC;
      ir_fault_q <= 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          state <= S_REQ;
        end
        S_REQ: begin
          if (bus.imem_gnt) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            ir_q       <= bus.imem_rdata;
            ir_pc_q    <= pc_q;
            ir_fault_q <= bus.imem_err;
            state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          // The hand-off cycle: pc_source and the targets are sampled only here
          if (bus.ir_ready) begin
            pc_q       <= next_pc;
            ir_q       <= NOP_INSTR;
            ir_fault_q <= 1'b0;
            state      <= S_REQ;
          end
        end
        default: begin
          state <= S_BOOT;
        end
      endcase
    end
  end

  // Handshake outputs are decoded from the state register alone, so there is
  // no combinational path from any input to imem_req or ir_valid.
  assign bus.imem_req  = (state == S_REQ);
  assign bus.imem_addr = pc_q;
  assign bus.ir_valid  = (state == S_HOLD);
  assign bus.ir        = ir_q;
  assign bus.ir_pc     = ir_pc_q;
  assign bus.ir_fault  = ir_fault_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_otter_fetch_unit.sv
module tb_otter_fetch_unit;

  localparam logic [31:0] RESET_VEC = 32'h0000_0100;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  otter_fetch_unit_if bus ();

  otter_fetch_unit #(
    .RESET_VEC (RESET_VEC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];   // expected IR words, pushed when rdata is driven
  logic [31:0] addr_q[$];  // expected fetch addresses, pushed at each hand-off
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_ir;
  logic [31:0] last_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge. Inputs are driven and
  // outputs sampled at this point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // Serve one fetch: wait (bounded) for the request, optionally stall the
  // grant, optionally pulse rvalid while still in REQ, then return data after
  // rv_dly extra wait cycles.
  task automatic fetch(input logic [31:0] rdata, input logic err,
                       input int gnt_dly, input int rv_dly, input bit rv_in_req);
    logic [31:0] a;
    logic [31:0] e;
    int n;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("req_seen", {31'd0, bus.imem_req}, 32'd1);
    a = (addr_q.size() != 0) ? addr_q.pop_front() : 32'hDEAD_BEEF;
    check("imem_addr", bus.imem_addr, a);
    for (int i = 0; i < gnt_dly; i++) begin
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = rv_in_req && (i == 0);
      bus.imem_rdata  = $urandom;
      tick();
      bus.imem_rvalid = 1'b0;
      check("req_held", {31'd0, bus.imem_req}, 32'd1);
      check("addr_stable", bus.imem_addr, a);
      check("no_valid_in_req", {31'd0, bus.ir_valid}, 32'd0);
    end
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    check("req_drop_after_gnt", {31'd0, bus.imem_req}, 32'd0);
    for (int i = 0; i < rv_dly; i++) begin
      tick();
      check("wait_no_valid", {31'd0, bus.ir_valid}, 32'd0);
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = rdata;
    bus.imem_err    = err;
    exp_q.push_back(rdata);
    tick();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom;
    bus.imem_err    = 1'b0;
    e = exp_q.pop_front();
    check("ir_valid", {31'd0, bus.ir_valid}, 32'd1);
    check("ir", bus.ir, e);
    check("ir_pc", bus.ir_pc, a);
    check("ir_fault", {31'd0, bus.ir_fault}, {31'd0, err});
    last_ir = e;
    last_pc = a;
  endtask

  // Hold the IR for 'hold' cycles with random decoder inputs, then hand off
  // with pc_source=src. The target goes on the field that src selects.
  task automatic handoff(input logic [3:0] src, input logic [31:0] tgt,
                         input int hold, input logic [31:0] exp_next);
    for (int i = 0; i < hold; i++) begin
      bus.ir_ready    = 1'b0;
      bus.pc_source   = 4'($urandom_range(0, 15));
      bus.jalr_addr   = $urandom;
      bus.branch_addr = $urandom;
      bus.jal_addr    = $urandom;
      bus.mtvec       = $urandom;
      bus.mepc        = $urandom;
      bus.imem_rvalid = (i == 0);
      tick();
      bus.imem_rvalid = 1'b0;
      check("hold_valid", {31'd0, bus.ir_valid}, 32'd1);
      check("hold_ir", bus.ir, last_ir);
      check("hold_ir_pc", bus.ir_pc, last_pc);
      check("hold_no_req", {31'd0, bus.imem_req}, 32'd0);
    end
    bus.pc_source   = src;
    bus.jalr_addr   = (src == 4'd1) ? tgt : 32'($urandom);
    bus.branch_addr = (src == 4'd2) ? tgt : 32'($urandom);
    bus.jal_addr    = (src == 4'd3) ? tgt : 32'($urandom);
    bus.mtvec       = (src == 4'd4) ? tgt : 32'($urandom);
    bus.mepc        = (src == 4'd5) ? tgt : 32'($urandom);
    bus.ir_ready    = 1'b1;
    addr_q.push_back(exp_next);
    tick();
    bus.ir_ready  = 1'b0;
    bus.pc_source = 4'($urandom_range(0, 15));
    bus.jal_addr  = $urandom;
    check("handoff_valid_clr", {31'd0, bus.ir_valid}, 32'd0);
    check("handoff_ir_nop", bus.ir, NOP_INSTR);
    check("handoff_next_req", {31'd0, bus.imem_req}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n           = 1'b0;
    bus.pc_source   = 4'd0;
    bus.jalr_addr   = 32'd0;
    bus.branch_addr = 32'd0;
    bus.jal_addr    = 32'd0;
    bus.mtvec       = 32'd0;
    bus.mepc        = 32'd0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'd0;
    bus.imem_err    = 1'b0;
    bus.ir_ready    = 1'b0;
    last_ir         = NOP_INSTR;
    last_pc         = RESET_VEC;

    // reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    end
    check("rst_addr", bus.imem_addr, RESET_VEC);
    check("rst_valid", {31'd0, bus.ir_valid}, 32'd0);
    check("rst_ir", bus.ir, NOP_INSTR);
    check("rst_ir_pc", bus.ir_pc, RESET_VEC);
    check("rst_fault", {31'd0, bus.ir_fault}, 32'd0);
    rst_n = 1'b1;
    check("boot_state", {30'd0, dbg_state}, 32'd0);
    check("boot_req", {31'd0, bus.imem_req}, 32'd0);
    tick();
    check("cycle1_req", {31'd0, bus.imem_req}, 32'd1);
    check("cycle1_addr", bus.imem_addr, 32'h100);

    // boot fetch, minimum latency
    addr_q.push_back(32'h100);
    fetch(32'h0050_0093, 1'b0, 0, 0, 1'b0);

    // sequential with 4 cycles of back-pressure
    handoff(4'd0, 32'd0, 4, 32'h104);
    fetch(32'h0040_0113, 1'b0, 0, 0, 1'b0);

    // redirects
    handoff(4'd3, 32'h200, 0, 32'h200);
    fetch($urandom, 1'b0, 0, 0, 1'b0);
    handoff(4'd1, 32'h303, 1, 32'h300);
    fetch($urandom, 1'b0, 3, 0, 1'b1);          // grant stall + rvalid in REQ
    handoff(4'd2, 32'h1F0, 0, 32'h1F0);
    fetch(32'hFFFF_FFFF, 1'b1, 0, 5, 1'b0);     // slow response with bus error
    handoff(4'd3, 32'h400, 2, 32'h400);
    fetch($urandom, 1'b0, 1, 1, 1'b0);
    handoff(4'd4, 32'h80, 0, 32'h80);
    fetch($urandom, 1'b0, 0, 0, 1'b0);
    handoff(4'd5, 32'h204, 0, 32'h204);
    fetch($urandom, 1'b0, 0, 0, 1'b0);
    handoff(4'd2, 32'h200, 0, 32'h200);
    fetch($urandom, 1'b0, 0, 0, 1'b0);
    handoff(4'd9, 32'h0, 0, 32'h204);           // unused encoding -> PC+4
    fetch($urandom, 1'b0, 0, 0, 1'b0);

    // wrap-around (misaligned JALR rounds down to FFFF_FFFC first)
    handoff(4'd1, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFC);
    fetch($urandom, 1'b0, 0, 0, 1'b0);
    handoff(4'd0, 32'h0, 0, 32'h0000_0000);
    fetch($urandom, 1'b0, 0, 0, 1'b0);
    handoff(4'd0, 32'h0, 0, 32'h0000_0004);

    // reset while waiting for read data
    check("mid_addr", bus.imem_addr, addr_q.pop_front());
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    check("mid_in_wait", {30'd0, dbg_state}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    tick();
    rst_n = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAD0_BAD0;
    tick();
    tick();
    bus.imem_rvalid = 1'b0;
    check("late_rv_valid", {31'd0, bus.ir_valid}, 32'd0);
    check("late_rv_ir", bus.ir, NOP_INSTR);
    check("restart_req", {31'd0, bus.imem_req}, 32'd1);
    check("restart_addr", bus.imem_addr, RESET_VEC);
    addr_q.push_back(RESET_VEC);
    fetch(32'h0000_0513, 1'b0, 0, 0, 1'b0);

    check("exp_q_empty", exp_q.size(), 32'd0);
    check("addr_q_empty", addr_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the bench always ends
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
